// File: rtl/rtc_pkg.sv
// Shared definitions for the V3023 RTC access blocks: bus widths, refresh
// defaults and the access sequencer state encoding.
package rtc_pkg;

    localparam int RTC_ADDR_W = 8;
    localparam int RTC_DATA_W = 8;

    localparam logic [RTC_ADDR_W-1:0] DEFAULT_BASE_ADDR = 8'h21;
    localparam int                    DEFAULT_NUM_REGS  = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } rtc_state_t;

endpackage

// File: rtl/rtc_watchdog.sv
// Cycle watchdog for RTC transfers: cleared by the owner, counts while
// enabled, and pulses expire on the TIMEOUT-th enabled cycle.
module rtc_watchdog #(
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && !clear && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/rtc_access_sequencer.sv
// Arbitrates user writes and periodic refresh reads onto the shared V3023
// transfer engine, drives the multiplexed A/D bus and builds the snapshot.
module rtc_access_sequencer
    import rtc_pkg::*;
#(
    parameter int                    NUM_REGS  = DEFAULT_NUM_REGS,
    parameter logic [RTC_ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int                    TIMEOUT   = 63
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_req,
    input  logic [RTC_ADDR_W-1:0]          wr_addr,
    input  logic [RTC_DATA_W-1:0]          wr_data,
    output logic                           wr_ack,
    input  logic                           refresh_tick,
    output logic [RTC_DATA_W*NUM_REGS-1:0] snap_data,
    output logic                           snap_valid,
    output logic                           busy,
    output logic                           timeout_err,
    output logic                           acceso,
    output logic                           rd_nwr,
    input  logic                           avalid,
    input  logic                           wvalid,
    input  logic                           rvalid,
    input  logic                           frw,
    output logic [RTC_DATA_W-1:0]          bus_out,
    output logic                           bus_oe,
    input  logic [RTC_DATA_W-1:0]          bus_in
);

    localparam int IDX_W = 3;

    rtc_state_t              state;
    logic [IDX_W-1:0]        idx;
    logic                    pending;
    logic [RTC_ADDR_W-1:0]   addr_q;
    logic [RTC_DATA_W-1:0]   data_q;
    logic [RTC_DATA_W-1:0]   capture;
    logic                    wd_expire;

    rtc_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (6)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .enable ((state == ST_LAUNCH) || (state == ST_WAIT)),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            pending     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            acceso      <= 1'b0;
            rd_nwr      <= 1'b0;
            wr_ack      <= 1'b0;
            snap_valid  <= 1'b0;
            snap_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            wr_ack     <= 1'b0;
            snap_valid <= 1'b0;
            if (refresh_tick) begin
                pending <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (wr_req) begin
                        addr_q <= wr_addr;
                        data_q <= wr_data;
                        rd_nwr <= 1'b0;
                        acceso <= 1'b1;
                        state  <= ST_LAUNCH;
                    end else if (pending) begin
                        addr_q <= BASE_ADDR + RTC_ADDR_W'(idx);
                        rd_nwr <= 1'b1;
                        acceso <= 1'b1;
                        state  <= ST_LAUNCH;
                    end
                end

                // An early frw is taken as a normal completion.
                ST_LAUNCH: begin
                    if (frw) begin
                        acceso <= 1'b0;
                        wr_ack <= !rd_nwr;
                        state  <= ST_DONE;
                    end else if (wd_expire) begin
                        acceso      <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (avalid) begin
                        acceso <= 1'b0;
                        state  <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (frw) begin
                        wr_ack <= !rd_nwr;
                        state  <= ST_DONE;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                // Clearing pending here also drops a tick landing on the last read.
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (rd_nwr) begin
                        snap_data[int'(idx)*RTC_DATA_W +: RTC_DATA_W] <= capture;
                        if (idx == IDX_W'(NUM_REGS - 1)) begin
                            idx        <= '0;
                            pending    <= 1'b0;
                            snap_valid <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            capture <= '0;
        end else if (rvalid && rd_nwr) begin
            capture <= bus_in;
        end
    end

    assign busy = (state != ST_IDLE);

    // NOTE: every output of this combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        bus_oe  = 1'b0;
        bus_out = '0;
        if (state != ST_IDLE) begin
            if (avalid) begin
                bus_oe  = 1'b1;
                bus_out = addr_q;
            end else if (wvalid && !rd_nwr) begin
                bus_oe  = 1'b1;
                bus_out = data_q;
            end
        end
    end

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Directed bench for rtc_access_sequencer with a behavioural transfer engine
// (avalid 5-14, wvalid 20-28, rvalid 25-28, frw at 36 after acceso is seen).
module tb_rtc_access_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        refresh_tick;
    logic [47:0] snap_data;
    logic        snap_valid;
    logic        busy;
    logic        timeout_err;
    logic        acceso;
    logic        rd_nwr;
    logic        avalid;
    logic        wvalid;
    logic        rvalid;
    logic        frw;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [7:0]  bus_in;

    int tests_run    = 0;
    int tests_failed = 0;

    // Engine model state and access log
    int         eng_cyc = 0;
    logic       eng_rd  = 1'b0;
    logic [7:0] eng_addr  = 8'h00;
    logic [7:0] eng_wdata = 8'h00;
    logic       hold_frw  = 1'b0;
    logic [7:0] rd_base   = 8'h00;
    int         eng_dir_err = 0;
    int         eng_bus_err = 0;
    logic       log_rd[128];
    logic [7:0] log_addr[128];
    logic [7:0] log_data[128];
    int         log_n = 0;

    int         ack_cnt   = 0;
    int         snapv_cnt = 0;
    logic [7:0] snapv_last_addr = 8'h00;

    rtc_access_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .refresh_tick (refresh_tick),
        .snap_data    (snap_data),
        .snap_valid   (snap_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .acceso       (acceso),
        .rd_nwr       (rd_nwr),
        .avalid       (avalid),
        .wvalid       (wvalid),
        .rvalid       (rvalid),
        .frw          (frw),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .bus_in       (bus_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge; the requester drops
    // wr_req as soon as it sees wr_ack.
    task automatic step();
        @(negedge clk);
        #1;
        if (wr_ack) wr_req = 1'b0;
    endtask

    task automatic pulse_tick();
        refresh_tick = 1'b1;
        step();
        refresh_tick = 1'b0;
    endtask

    task automatic wait_snapv(input string tag, input int target, input int max_cyc);
        int n = 0;
        while (snapv_cnt < target && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, snapv_cnt >= target, 1'b1);
    endtask

    task automatic check_burst(input string tag, input int mark);
        check({tag, "_count"}, log_n - mark, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_rd%0d", tag, i), log_rd[mark+i], 1'b1);
            check($sformatf("%s_addr%0d", tag, i), log_addr[mark+i], 8'h21 + 8'(i));
        end
    endtask

    // Transfer engine model, driven on falling edges
    initial begin
        avalid = 1'b0; wvalid = 1'b0; rvalid = 1'b0; frw = 1'b0; bus_in = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_cyc != 0 && reset) begin
                if (rd_nwr != eng_rd) eng_dir_err++;
                if (avalid) begin
                    if (!bus_oe) eng_bus_err++;
                    if (eng_cyc > 5 && bus_out != eng_addr) eng_bus_err++;
                    eng_addr = bus_out;
                end else if (wvalid) begin
                    if (!bus_oe) eng_bus_err++;
                    eng_wdata = bus_out;
                end else if (bus_oe) begin
                    eng_bus_err++;
                end
            end
            if (!reset) begin
                eng_cyc = 0;
            end else if (eng_cyc == 0) begin
                if (acceso) begin
                    eng_cyc   = 1;
                    eng_rd    = rd_nwr;
                    eng_addr  = 8'h00;
                    eng_wdata = 8'h00;
                end
            end else begin
                eng_cyc++;
                if (eng_cyc > 36) eng_cyc = 0;
            end
            avalid = (eng_cyc >= 5 && eng_cyc <= 14);
            wvalid = !eng_rd && (eng_cyc >= 20 && eng_cyc <= 28);
            rvalid = eng_rd && (eng_cyc >= 25 && eng_cyc <= 28);
            frw    = (eng_cyc == 36) && !hold_frw;
            bus_in = rvalid ? rd_base + (eng_addr - 8'h21) : 8'h00;
            if (frw && log_n < 128) begin
                log_rd[log_n]   = eng_rd;
                log_addr[log_n] = eng_addr;
                log_data[log_n] = eng_wdata;
                log_n++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (wr_ack) ack_cnt++;
            if (snap_valid) begin
                snapv_cnt++;
                if (log_n > 0) snapv_last_addr = log_addr[log_n-1];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mark, mark2, a0, s0, n, cnt, acc_hi, quiet, new_b, err;
        logic       exp_rd[7]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_addr[7] = '{8'h21, 8'h22, 8'h23, 8'h05, 8'h24, 8'h25, 8'h26};

        reset = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00; refresh_tick = 1'b0;
        repeat (3) step();
        check("rst_acceso", acceso, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_snap_data", snap_data, 48'h0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_bus_oe", bus_oe, 1'b0);
        check("rst_wr_ack", wr_ack, 1'b0);
        check("rst_snap_valid", snap_valid, 1'b0);
        reset = 1'b1;
        repeat (2) step();

        // 1. User write
        mark = log_n; a0 = ack_cnt;
        wr_addr = 8'h22; wr_data = 8'h45; wr_req = 1'b1;
        step();
        check("t1_latency_acceso", acceso, 1'b1);
        check("t1_busy", busy, 1'b1);
        acc_hi = 1; n = 0;
        while (ack_cnt == a0 && n < 200) begin
            step();
            if (acceso) acc_hi++;
            n++;
        end
        check("t1_ack_seen", ack_cnt - a0, 1);
        check("t1_acceso_cycles", acc_hi, 5);
        repeat (10) step();
        check("t1_single_ack", ack_cnt - a0, 1);
        check("t1_log_count", log_n - mark, 1);
        check("t1_dir", log_rd[mark], 1'b0);
        check("t1_bus_addr", log_addr[mark], 8'h22);
        check("t1_bus_data", log_data[mark], 8'h45);
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_bus_oe", bus_oe, 1'b0);

        // 2. Refresh burst
        rd_base = 8'h10; mark = log_n; s0 = snapv_cnt;
        pulse_tick();
        wait_snapv("t2_snapv_seen", s0 + 1, 600);
        check_burst("t2", mark);
        check("t2_snap_data", snap_data, 48'h151413121110);
        repeat (20) step();
        check("t2_single_snapv", snapv_cnt - s0, 1);

        // 3. Write arriving during read 2 of a burst
        rd_base = 8'h30; mark = log_n; s0 = snapv_cnt; a0 = ack_cnt;
        pulse_tick();
        n = 0;
        while (!(eng_rd && eng_addr == 8'h23 && eng_cyc >= 10) && n < 400) begin
            step();
            n++;
        end
        check("t3_read2_reached", n < 400, 1'b1);
        wr_addr = 8'h05; wr_data = 8'hA5; wr_req = 1'b1;
        wait_snapv("t3_snapv_seen", s0 + 1, 800);
        check("t3_log_count", log_n - mark, 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t3_rd%0d", i), log_rd[mark+i], exp_rd[i]);
            check($sformatf("t3_addr%0d", i), log_addr[mark+i], exp_addr[i]);
        end
        check("t3_wdata", log_data[mark+3], 8'hA5);
        check("t3_snap_data", snap_data, 48'h353433323130);
        check("t3_snapv_after_last", snapv_last_addr, 8'h26);
        check("t3_ack", ack_cnt - a0, 1);

        // 4. Watchdog expiry on a write, then retry
        hold_frw = 1'b1; mark = log_n; a0 = ack_cnt;
        wr_addr = 8'h30; wr_data = 8'h5A; wr_req = 1'b1;
        n = 0;
        while (!acceso && n < 20) begin
            step();
            n++;
        end
        check("t4_launch_seen", acceso, 1'b1);
        cnt = 0;
        while (!timeout_err && cnt < 200) begin
            step();
            cnt++;
        end
        hold_frw = 1'b0;
        check("t4_timeout_cycles", cnt, 63);
        check("t4_no_ack", ack_cnt - a0, 0);
        check("t4_no_log", log_n - mark, 0);
        n = 0;
        while (ack_cnt == a0 && n < 300) begin
            step();
            n++;
        end
        check("t4_retry_ack", ack_cnt - a0, 1);
        check("t4_retry_addr", log_addr[log_n-1], 8'h30);
        check("t4_retry_data", log_data[log_n-1], 8'h5A);
        check("t4_sticky", timeout_err, 1'b1);

        // 5. Reset in the middle of a read
        rd_base = 8'h50; repeat (5) step();
        pulse_tick();
        n = 0;
        while (!(eng_rd && eng_addr == 8'h23 && eng_cyc >= 20) && n < 400) begin
            step();
            n++;
        end
        check("t5_wait_reached", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_acceso", acceso, 1'b0);
        check("t5_bus_oe", bus_oe, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_timeout_clr", timeout_err, 1'b0);
        check("t5_snap_clr", snap_data, 48'h0);
        step();
        reset = 1'b1;
        repeat (10) step();
        check("t5_no_resume", busy, 1'b0);
        mark2 = log_n; s0 = snapv_cnt;
        pulse_tick();
        wait_snapv("t5_snapv_seen", s0 + 1, 600);
        check_burst("t5", mark2);
        check("t5_snap_data", snap_data, 48'h555453525150);

        // 6. Tick flood
        rd_base = 8'h70; mark = log_n; s0 = snapv_cnt;
        for (int c = 0; c < 500; c++) begin
            refresh_tick = (c % 10 == 0);
            step();
        end
        refresh_tick = 1'b0;
        quiet = 0; n = 0;
        while (quiet < 3 && n < 1000) begin
            step();
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        check("t6_drain", quiet >= 3, 1'b1);
        new_b = snapv_cnt - s0;
        check("t6_bursts", new_b >= 2, 1'b1);
        check("t6_entries", log_n - mark, 6 * new_b);
        err = 0;
        for (int k = 0; k < log_n - mark; k++) begin
            if (!log_rd[mark+k] || log_addr[mark+k] != 8'h21 + 8'(k % 6)) err++;
        end
        check("t6_addr_sequence", err, 0);
        check("t6_snap_data", snap_data, 48'h757473727170);

        check("dir_stable", eng_dir_err, 0);
        check("bus_windows", eng_bus_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
